// File: rtl/bp_me_stream_pump_out.sv
// Outbound stream pump: FSM beats in, wrapped-address stream beats out via a two-entry FIFO.
// Latency: 1 cycle from FSM handshake to mem_v_o; throughput 1 beat/cycle; FSM stalls on a full FIFO.

module bp_me_stream_two_fifo #(
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               ready_o,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  input  logic               yumi_i
);
  logic [width_p-1:0] slot_q [2];
  logic               wptr_q, rptr_q;
  logic [1:0]         count_q, count_d;
  logic               enq, deq;

  assign ready_o = (count_q != 2'd2);
  assign v_o     = (count_q != 2'd0);
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o;
  assign data_o  = slot_q[rptr_q];

  always_comb begin
    count_d = count_q;
    if (enq & ~deq)      count_d = count_q + 2'd1;
    else if (deq & ~enq) count_d = count_q - 2'd1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      count_q <= count_d;
      if (enq) wptr_q <= ~wptr_q;
      if (deq) rptr_q <= ~rptr_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) slot_q[wptr_q] <= data_i;
  end
endmodule

module bp_me_stream_pump_out #(
  parameter int          paddr_width_p       = 40,
  parameter int          stream_data_width_p = 64,
  parameter int          block_width_p       = 512,
  parameter logic [15:0] mem_stream_mask_p   = '0,
  parameter logic [15:0] fsm_stream_mask_p   = mem_stream_mask_p,
  localparam int xce_mem_msg_header_width_lp = 4 + 3 + paddr_width_p,
  localparam int data_len_width_lp =
    (block_width_p > stream_data_width_p) ? $clog2(block_width_p / stream_data_width_p) : 1
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic [xce_mem_msg_header_width_lp-1:0] fsm_base_header_i,
  input  logic [stream_data_width_p-1:0]         fsm_data_i,
  input  logic                                   fsm_v_i,
  output logic                                   fsm_ready_and_o,
  output logic [data_len_width_lp-1:0]           fsm_cnt_o,
  output logic                                   fsm_new_o,
  output logic                                   fsm_last_o,
  output logic                                   fsm_done_o,
  output logic [xce_mem_msg_header_width_lp-1:0] mem_header_o,
  output logic [stream_data_width_p-1:0]         mem_data_o,
  output logic                                   mem_v_o,
  output logic                                   mem_last_o,
  input  logic                                   mem_ready_and_i
);
  localparam int stream_offset_lp = $clog2(stream_data_width_p / 8);

  if ((stream_data_width_p % 8) != 0 || stream_data_width_p < 8) begin : g_bad_stream
    $error("stream_data_width_p must be a whole number of bytes");
  end
  if ((block_width_p % stream_data_width_p) != 0 || block_width_p < stream_data_width_p) begin : g_bad_block
    $error("block_width_p must be a multiple of, and at least, stream_data_width_p");
  end
  if (data_len_width_lp > 8 || stream_offset_lp + data_len_width_lp > paddr_width_p) begin : g_bad_len
    $error("beat count field does not fit the address");
  end

  typedef struct packed {
    logic [3:0]               msg_type;
    logic [2:0]               size;
    logic [paddr_width_p-1:0] addr;
  } hdr_t;

  typedef struct packed {
    logic                           last;
    hdr_t                           hdr;
    logic [stream_data_width_p-1:0] data;
  } beat_t;

  hdr_t                         hdr, out_hdr;
  beat_t                        enq_beat, head_beat;
  logic [8:0]                   num_beats;
  logic [data_len_width_lp-1:0] beat_mask, first_cnt, wrap_cnt;
  logic [paddr_width_p-1:0]     wrap_addr;
  logic [data_len_width_lp-1:0] cnt_q, cnt_d;
  logic                         streaming_q, streaming_d;
  logic                         fsm_stream, mem_stream, is_last, step;
  logic                         fifo_v, fifo_ready, enq_last;

  assign hdr = hdr_t'(fsm_base_header_i);

  always_comb begin
    num_beats = (9'd1 << hdr.size) >> stream_offset_lp;
    if (num_beats == 9'd0) num_beats = 9'd1;
  end

  assign beat_mask  = data_len_width_lp'(num_beats - 9'd1);
  assign fsm_stream = fsm_stream_mask_p[hdr.msg_type] & (num_beats > 9'd1);
  assign mem_stream = mem_stream_mask_p[hdr.msg_type] & (num_beats > 9'd1);
  assign is_last    = ~(fsm_stream | mem_stream) | (cnt_q == beat_mask);

  // Only the low log2(num_beats) bits of the critical word index wrap.
  assign first_cnt = hdr.addr[stream_offset_lp +: data_len_width_lp];
  assign wrap_cnt  = (first_cnt & ~beat_mask) | ((first_cnt + cnt_q) & beat_mask);

  always_comb begin
    wrap_addr = hdr.addr;
    wrap_addr[stream_offset_lp +: data_len_width_lp] = wrap_cnt;
  end

  always_comb begin
    out_hdr         = hdr;
    out_hdr.addr    = wrap_addr;
    fsm_last_o      = is_last;
    fsm_ready_and_o = fifo_ready;
    fifo_v          = fsm_v_i;
    enq_last        = is_last;
    step            = fsm_v_i & fifo_ready;
    if (fsm_stream & ~mem_stream) begin
      // N:1 collapses to one beat carrying the critical address.
      out_hdr.addr    = hdr.addr;
      fsm_ready_and_o = is_last ? fifo_ready : 1'b1;
      fifo_v          = fsm_v_i & is_last;
      enq_last        = 1'b1;
      step            = fsm_v_i & fsm_ready_and_o;
    end else if (mem_stream & ~fsm_stream) begin
      fsm_last_o      = 1'b1;
      fsm_ready_and_o = is_last & fifo_ready;
    end
  end

  always_comb begin
    cnt_d       = cnt_q;
    streaming_d = streaming_q;
    if (step) begin
      if (is_last) begin
        cnt_d       = '0;
        streaming_d = 1'b0;
      end else begin
        cnt_d       = cnt_q + data_len_width_lp'(1);
        streaming_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q       <= '0;
      streaming_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      streaming_q <= streaming_d;
    end
  end

  assign fsm_cnt_o  = wrap_cnt;
  assign fsm_new_o  = ~streaming_q & fsm_stream;
  assign fsm_done_o = fsm_last_o & fsm_v_i & fsm_ready_and_o;

  assign enq_beat = '{last: enq_last, hdr: out_hdr, data: fsm_data_i};

  bp_me_stream_two_fifo #(.width_p($bits(beat_t))) out_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .data_i  (enq_beat),
    .v_i     (fifo_v),
    .ready_o (fifo_ready),
    .data_o  (head_beat),
    .v_o     (mem_v_o),
    .yumi_i  (mem_ready_and_i)
  );

  assign mem_header_o = head_beat.hdr;
  assign mem_data_o   = head_beat.data;
  assign mem_last_o   = head_beat.last;

  assert property (@(posedge clk_i) disable iff (reset_i) streaming_q |-> $stable(fsm_base_header_i))
    else $error("fsm_base_header_i changed mid-message");
endmodule

// File: doc/bp_me_stream_pump_out.md
Name: bp_me_stream_pump_out

Overview:
- Outbound counterpart to the inbound stream pump. Takes FSM-produced beats (base header + data) and emits a BedRock Stream message (header, data, last) toward memory or the network.
- Generates per-beat wrap-around addresses and FSM control (new/done/cnt).
- Absorbs N FSM beats into one output beat, or expands one FSM beat into N output beats, per message-type masks.
- Output side is buffered by a two-element FIFO.

Parameters:
bp_params_p, e_bp_default_cfg, processor config; supplies paddr_width_p, lce_id_width_p, lce_assoc_p.
stream_data_width_p, dword_width_gp, data beat width in bits.
block_width_p, cce_block_width_p, max message payload; must be a multiple of and ≥ stream_data_width_p.
mem_stream_mask_p, 0, bit per msg_type: output side of that type is multi-beat.
fsm_stream_mask_p, mem_stream_mask_p, bit per msg_type: FSM side of that type is multi-beat.

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
fsm_base_header_i  in  xce_mem_msg_header_width_lp  message header; addr holds the critical-word address; held stable for the whole message
fsm_data_i  in  stream_data_width_p  beat data
fsm_v_i  in  1  FSM beat valid
fsm_ready_and_o  out  1  beat accepted when fsm_v_i & fsm_ready_and_o
fsm_cnt_o  out  data_len_width_lp  wrapped word index of the current FSM beat
fsm_new_o  out  1  current FSM beat is the first of a multi-beat FSM message
fsm_last_o  out  1  current FSM beat is the final FSM beat of the message
fsm_done_o  out  1  fsm_last_o & FSM handshake this cycle
mem_header_o  out  xce_mem_msg_header_width_lp  output header, addr = per-beat wrapped address
mem_data_o  out  stream_data_width_p  output data
mem_v_o  out  1  output valid
mem_last_o  out  1  final output beat of the message
mem_ready_and_i  in  1  downstream ready

Behaviour:
- Reset values: mem_v_o=0, streaming_r=0, beat counter=0; fsm_ready_and_o=1 one cycle after reset deasserts.
- num_beats = max((1<<size)/(stream_data_width_p/8), 1).
- first_cnt = addr[stream_offset +: data_len_width].
- A message is multi-beat only if its mask bit is set and num_beats>1.
- Wrap rule: beat k count = (first_cnt + k) mod num_beats, replacing only the low log2(num_beats) bits of first_cnt.
  - Out-addr = {addr upper, mux_bitwise(addr cnt bits, cnt, num_beats-1), addr low offset}.
  - Example (size=256b, first=2): counts 2,3,0,1.
- Output FIFO: bsg_two_fifo holding {last, header, data}.
  - mem_* outputs come from the FIFO head; the head is dequeued on mem_v_o & mem_ready_and_i.
  - Minimum latency from FSM handshake to mem_v_o is 1 cycle; full throughput, 1 beat/cycle.
  - Output header/data are held stable while mem_v_o & ~mem_ready_and_i.
- N:N (both masks set, or neither): each FSM handshake enqueues one beat.
  - fsm_ready_and_o = fifo ready.
  - Enqueued mem_last = fsm_last_o.
- N:1 (fsm mask only): non-last FSM beats are accepted without waiting on the FIFO (fsm_ready_and_o=1) and are not enqueued.
  - The last FSM beat waits for fifo ready and enqueues a single beat with last=1.
  - That beat's header addr is the critical address (no wrap).
- 1:N (mem mask only): a single FSM beat expands into num_beats output enqueues.
  - fsm_ready_and_o is asserted only on the final expansion cycle, when the fifo is ready.
  - Data is repeated on every expanded beat; the header addr wraps per beat.
  - last=1 on the final beat only.
- Counter/state:
  - bsg_counter_set_en; streaming_r is set on any non-final counted step and cleared on the final step (clear wins over set).
  - The counter reloads to 0 at message end.
  - fsm_new_o = ~streaming_r & fsm-side multi-beat.
  - Single-beat messages never set streaming_r.
- Header is sampled combinationally from fsm_base_header_i every beat. The FSM must not change it mid-message; this is a checked assertion.
- Reset mid-message: the counter, streaming_r, and FIFO are all cleared. The next message restarts at its first_cnt, with no stale beats emitted.
- Back-pressure on the last beat: fsm_done_o pulses only on the handshake cycle, never on a stall.
- Elaboration asserts the divisibility and width rules on the parameters.

Test Plan:
- Stream 64b, block 512b, wr size 64B addr 0x1010, both masks: 8 FSM beats → out addrs 0x1010,0x1018,0x1020…0x1038,0x1000,0x1008; mem_last on the 8th only; fsm_new on beat 0 only; fsm_done on beat 8.
- 1:N read 64B addr 0x2000 (mem mask only): 1 FSM beat data 0xAB → 8 out beats each data 0xAB, addrs 0x2000..0x2038, last on the 8th; fsm_ready_and_o high only on cycle 8.
- N:1 (fsm mask only) 32B addr 0x3008: 4 FSM beats → exactly 1 out beat, addr 0x3008, last=1, data = 4th beat data.
- Back-pressure: mem_ready_and_i low for 5 cycles during N:N → FIFO fills after 2 beats, fsm_ready_and_o=0, outputs stable, no beat lost or duplicated; resume gives in-order delivery.
- Single-beat 8B uncached write with masks set: 1 in → 1 out, last=1, fsm_new=0, fsm_done=1, streaming_r stays 0.
- Assert reset_i after 3 of 8 beats → mem_v_o=0 next cycle; the following 64B msg addr 0x4030 starts with count 6 and sequence 6,7,0..5.
